core_run_ctrl: RTL and testbench

- Run/stop sequencer for the processor core; produces the core enable that gates PC, register-file and data-memory updates plus the cycle/jump/branch counters.
- Arbitrates four stop sources: decoded halt instruction, PC breakpoint, cycle budget and single-step mode.
- Restarts on a synchronized rising edge of the resume push-button.
- Sits in the top level between the switch/button I/O and the core.

---
 rtl/core_run_ctrl_pkg.sv | 22 ++
 rtl/aux_edge_sync.sv | 30 +++
 rtl/core_run_ctrl.sv | 109 ++++++++++
 tb/tb_core_run_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the core run/stop sequencer.
// State and cause codes are visible on the debug outputs, so their values are fixed.
package core_run_ctrl_pkg;

  localparam int StateBit = 2;
  localparam int CauseBit = 3;

  typedef enum logic [StateBit-1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2
  } run_state_e;

  typedef enum logic [CauseBit-1:0] {
    CS_NONE   = 3'd0,
    CS_HALT   = 3'd1,
    CS_BP     = 3'd2,
    CS_BUDGET = 3'd3,
    CS_STEP   = 3'd4
  } stop_cause_e;

endpackage

// File: rtl/aux_edge_sync.sv
// Multi-stage synchronizer for a raw button level followed by a registered
// rising-edge detector; pulse is high for one cycle, SyncStages+1 cycles after din rises.
module aux_edge_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SyncStages-1:0] sync_reg;
  logic                  prev_reg;
  logic                  pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SyncStages-2:0], din};
      prev_reg  <= sync_reg[SyncStages-1];
      pulse_reg <= sync_reg[SyncStages-1] && !prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/stop sequencer: gates the core with en and arbitrates halt, breakpoint,
// cycle budget and single-step stop sources; a resume press restarts from PAUSE.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int PcBit      = 32,
  parameter int BudgetBit  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resume,
  input  logic                 step_mode,
  input  logic                 bp_en,
  input  logic [PcBit-1:0]     bp_pc,
  input  logic [PcBit-1:0]     pc,
  input  logic                 halt,
  input  logic [BudgetBit-1:0] budget,
  output logic                 en,
  output logic [StateBit-1:0]  state,
  output logic [CauseBit-1:0]  cause,
  output logic [BudgetBit-1:0] stop_cnt
);

  logic                 rp;
  run_state_e           state_reg;
  stop_cause_e          cause_reg;
  logic [BudgetBit-1:0] stop_cnt_reg;
  logic [BudgetBit-1:0] run_cnt_reg;
  logic                 bp_skip_reg;

  logic                 bp_hit;
  logic                 budget_hit;
  logic [BudgetBit:0]   run_cnt_inc;

  aux_edge_sync #(
    .SyncStages(SyncStages)
  ) u_resume_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (resume),
    .pulse(rp)
  );

  // bp_skip lets the breakpoint instruction itself execute once after a resume.
  assign bp_hit      = bp_en && (pc == bp_pc) && !bp_skip_reg;
  assign run_cnt_inc = {1'b0, run_cnt_reg} + (BudgetBit + 1)'(1);
  assign budget_hit  = (budget != '0) && (run_cnt_inc >= {1'b0, budget});
  assign en          = !rst && (((state_reg == ST_RUN) && !bp_hit) || (state_reg == ST_STEP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      cause_reg    <= CS_NONE;
      stop_cnt_reg <= '0;
      run_cnt_reg  <= '0;
      bp_skip_reg  <= 1'b0;
    end else begin
      if (en && bp_skip_reg) begin
        bp_skip_reg <= 1'b0;
      end
      case (state_reg)
        ST_RUN: begin
          if (bp_hit) begin
            state_reg    <= ST_PAUSE;
            cause_reg    <= CS_BP;
            stop_cnt_reg <= stop_cnt_reg + BudgetBit'(1);
          end else if (halt) begin
            state_reg    <= ST_PAUSE;
            cause_reg    <= CS_HALT;
            stop_cnt_reg <= stop_cnt_reg + BudgetBit'(1);
          end else if (budget_hit) begin
            state_reg    <= ST_PAUSE;
            cause_reg    <= CS_BUDGET;
            stop_cnt_reg <= stop_cnt_reg + BudgetBit'(1);
          end else if (step_mode) begin
            state_reg    <= ST_PAUSE;
            cause_reg    <= CS_STEP;
            stop_cnt_reg <= stop_cnt_reg + BudgetBit'(1);
          end else if (run_cnt_reg != '1) begin
            run_cnt_reg <= run_cnt_inc[BudgetBit-1:0];
          end
        end
        ST_PAUSE: begin
          // Resume is honoured whatever the stop cause, including halt.
          if (rp) begin
            state_reg   <= step_mode ? ST_STEP : ST_RUN;
            cause_reg   <= CS_NONE;
            run_cnt_reg <= '0;
            bp_skip_reg <= 1'b1;
          end
        end
        ST_STEP: begin
          state_reg    <= ST_PAUSE;
          cause_reg    <= halt ? CS_HALT : CS_STEP;
          stop_cnt_reg <= stop_cnt_reg + BudgetBit'(1);
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign cause    = cause_reg;
  assign stop_cnt = stop_cnt_reg;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a per-cycle vector table for the stop
// priorities plus hand sequences driving a small looping-PC core model.
module tb_core_run_ctrl;

  localparam int Sync = 2;

  logic        clk = 1'b0;
  logic        rst, resume, step_mode, bp_en, halt;
  logic [31:0] bp_pc, pc;
  logic [15:0] budget;
  logic        en;
  logic [1:0]  state;
  logic [2:0]  cause;
  logic [15:0] stop_cnt;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] pc_m;

  always #5 clk = ~clk;

  core_run_ctrl #(.SyncStages(Sync), .PcBit(32), .BudgetBit(16)) dut (
    .clk(clk), .rst(rst), .resume(resume), .step_mode(step_mode), .bp_en(bp_en),
    .bp_pc(bp_pc), .pc(pc), .halt(halt), .budget(budget),
    .en(en), .state(state), .cause(cause), .stop_cnt(stop_cnt)
  );

  typedef struct {
    logic        rst, step_mode, bp_en;
    logic [31:0] pc;
    logic        halt;
    logic [15:0] budget;
    logic        exp_en;
    logic [1:0]  exp_state;
    logic [2:0]  exp_cause;
    logic [15:0] exp_stop;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic r, logic sm, logic be, logic [31:0] p, logic h,
                              logic [15:0] b, logic e, logic [1:0] s, logic [2:0] c,
                              logic [15:0] sc);
    vec_t v;
    v.rst = r; v.step_mode = sm; v.bp_en = be; v.pc = p; v.halt = h; v.budget = b;
    v.exp_en = e; v.exp_state = s; v.exp_cause = c; v.exp_stop = sc;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; resume = 1'b0; step_mode = 1'b0; bp_en = 1'b0; halt = 1'b0;
    budget = '0; pc = '0; pc_m = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive the core model until PAUSE is seen; halt is raised on en cycle number halt_at.
  task automatic run_until_pause(input string name, input int halt_at, output int n_en);
    bit paused;
    n_en = 0;
    paused = 1'b0;
    for (int c = 0; c < 200; c++) begin
      pc   = pc_m;
      halt = (n_en == halt_at);
      #1;
      if (state == 2'd1) begin
        paused = 1'b1;
        break;
      end
      if (en) begin
        n_en++;
        pc_m = (pc_m + 32'd4) & 32'h1c;
      end
      @(negedge clk);
    end
    halt = 1'b0;
    chk({name, "_paused"}, paused, 1);
    $display("run %s: %0d en cycles, cause=%0d stop_cnt=%0d", name, n_en, cause, stop_cnt);
  endtask

  // Raise resume from PAUSE and measure clock edges until the state changes.
  task automatic press_resume(input string name, input logic [1:0] exp_state);
    int lat;
    lat = -1;
    resume = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      if (state != 2'd1) begin
        lat = k;
        break;
      end
      chk({name, "_pause_en"}, en, 0);
    end
    resume = 1'b0;
    // rp appears Sync+1 edges after the pin; the FSM acts on it one edge later.
    chk({name, "_latency"}, lat, Sync + 2);
    chk({name, "_state"}, state, exp_state);
    chk({name, "_cause"}, cause, 0);
    $display("press %s: latency %0d edges, state=%0d", name, lat, state);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int cnt;

    bp_pc = 32'h10;
    rst = 1'b1; resume = 1'b0; step_mode = 1'b0; bp_en = 1'b0; halt = 1'b0;
    budget = '0; pc = '0; pc_m = '0;
    repeat (2) @(negedge clk);

    //            rst sm be pc      h  budget en st c  stop
    vecs[0]  = mk(1, 0, 0, 32'h00, 0, 16'd0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h00, 0, 16'd0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h04, 0, 16'd0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h08, 1, 16'd0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0c, 0, 16'd0, 0, 1, 1, 1);
    vecs[5]  = mk(1, 0, 0, 32'h0c, 0, 16'd0, 0, 1, 1, 1);
    vecs[6]  = mk(0, 0, 1, 32'h10, 1, 16'd0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 32'h10, 0, 16'd0, 0, 1, 2, 1);
    vecs[8]  = mk(1, 0, 0, 32'h10, 0, 16'd0, 0, 1, 2, 1);
    vecs[9]  = mk(0, 0, 0, 32'h20, 0, 16'd3, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 32'h24, 0, 16'd3, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 32'h28, 0, 16'd3, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h2c, 0, 16'd3, 0, 1, 3, 1);
    vecs[13] = mk(1, 0, 0, 32'h2c, 0, 16'd0, 0, 1, 3, 1);
    vecs[14] = mk(0, 1, 0, 32'h00, 0, 16'd0, 1, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 32'h04, 0, 16'd0, 0, 1, 4, 1);
    vecs[16] = mk(1, 0, 0, 32'h04, 0, 16'd0, 0, 1, 4, 1);
    vecs[17] = mk(0, 0, 0, 32'h04, 0, 16'd0, 1, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst; step_mode = vecs[i].step_mode; bp_en = vecs[i].bp_en;
      pc = vecs[i].pc; halt = vecs[i].halt; budget = vecs[i].budget;
      #1;
      chk($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
      chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      chk($sformatf("vec%0d_cause", i), cause, vecs[i].exp_cause);
      chk($sformatf("vec%0d_stop", i), stop_cnt, vecs[i].exp_stop);
      $display("vec %0d: en=%0d state=%0d cause=%0d stop_cnt=%0d", i, en, state, cause, stop_cnt);
      @(negedge clk);
    end

    // Halt on the 10th executed instruction, then resume.
    do_reset();
    run_until_pause("halt", 9, n);
    chk("halt_en_cycles", n, 10);
    chk("halt_cause", cause, 1);
    chk("halt_stop", stop_cnt, 1);
    chk("halt_en_off", en, 0);
    press_resume("halt_resume", 2'd0);

    // Breakpoint at 0x10 on a PC looping 0x00..0x1c.
    do_reset();
    bp_en = 1'b1;
    run_until_pause("bp1", -1, n);
    chk("bp1_en_cycles", n, 4);
    chk("bp1_cause", cause, 2);
    chk("bp1_pc_held", pc, 32'h10);
    press_resume("bp_resume", 2'd0);
    run_until_pause("bp2", -1, n);
    chk("bp2_en_cycles", n, 8);
    chk("bp2_cause", cause, 2);
    chk("bp2_stop", stop_cnt, 2);

    // Budget of 5, twice, then lowered to 2 with run_cnt at 3.
    do_reset();
    budget = 16'd5;
    run_until_pause("bud1", -1, n);
    chk("bud1_en_cycles", n, 5);
    chk("bud1_cause", cause, 3);
    press_resume("bud_resume1", 2'd0);
    run_until_pause("bud2", -1, n);
    chk("bud2_en_cycles", n, 5);
    chk("bud2_stop", stop_cnt, 2);
    press_resume("bud_resume2", 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bud3_en", en, 1);
      @(negedge clk);
      #1;
    end
    budget = 16'd2;
    #1;
    chk("bud_lower_en", en, 1);
    @(negedge clk);
    #1;
    chk("bud_lower_state", state, 1);
    chk("bud_lower_cause", cause, 3);
    chk("bud_lower_stop", stop_cnt, 3);

    // Single-step mode.
    do_reset();
    step_mode = 1'b1;
    run_until_pause("step0", -1, n);
    chk("step0_en_cycles", n, 1);
    chk("step0_cause", cause, 4);
    for (int p = 1; p <= 3; p++) begin
      idle(4);
      press_resume($sformatf("step%0d_press", p), 2'd2);
      run_until_pause($sformatf("step%0d", p), -1, n);
      chk($sformatf("step%0d_en_cycles", p), n, 1);
      chk($sformatf("step%0d_cause", p), cause, 4);
      chk($sformatf("step%0d_stop", p), stop_cnt, 1 + p);
    end
    idle(4);
    resume = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (en) cnt++;
    end
    resume = 1'b0;
    chk("step_held_en_cycles", cnt, 1);
    chk("step_held_state", state, 1);
    chk("step_held_stop", stop_cnt, 5);
    idle(4);
    press_resume("step_halt_press", 2'd2);
    run_until_pause("step_halt", 0, n);
    chk("step_halt_en_cycles", n, 1);
    chk("step_halt_cause", cause, 1);
    chk("step_halt_stop", stop_cnt, 6);

    // Reset from PAUSE with cause=BUDGET and stop_cnt=7.
    do_reset();
    budget = 16'd1;
    run_until_pause("rst_b0", -1, n);
    for (int p = 1; p <= 6; p++) begin
      idle(4);
      press_resume($sformatf("rst_press%0d", p), 2'd0);
      run_until_pause($sformatf("rst_b%0d", p), -1, n);
    end
    chk("pre_rst_cause", cause, 3);
    chk("pre_rst_stop", stop_cnt, 7);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_cause", cause, 0);
    chk("rst_stop", stop_cnt, 0);
    chk("rst_en", en, 0);
    budget = 16'd2;
    rst = 1'b0;
    run_until_pause("rst_runcnt", -1, n);
    chk("rst_runcnt_en_cycles", n, 2);

    // Resume held through reset produces an rp in RUN, which must be ignored.
    resume = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    budget = '0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (state == 2'd0 && en) cnt++;
    end
    resume = 1'b0;
    chk("held_rst_run_cycles", cnt, 12);
    $display("held resume through reset: %0d cycles in RUN", cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
